// File: rtl/dmem_arb_pkg.sv
// ============================================================================
//  Module   : dmem_arb_pkg
//  Purpose  : Shared types and constants for the data-memory arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    // Width of the aux wait counter; enough to hold MAX_WAIT up to 255
    localparam int WAIT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_AUX = 1'b1
    } owner_e;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_wait_ctr.sv
// ============================================================================
//  Module   : dmem_arb_wait_ctr
//  Purpose  : Counts cycles an aux request has waited behind the CPU.
//             o_tc flags that the pending increment reaches MAX_WAIT, so the
//             arbiter can schedule the forced slot for the following cycle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arb_wait_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    logic [WAIT_W-1:0] r_cnt;
    logic [WAIT_W:0]   w_cnt_inc;

    // One extra bit so the comparison never wraps at the top of the range
    assign w_cnt_inc = {1'b0, r_cnt} + {{WAIT_W{1'b0}}, 1'b1};
    assign o_tc      = (w_cnt_inc >= (WAIT_W + 1)'(MAX_WAIT));

    // Wait counter: clear has priority over increment
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= w_cnt_inc[WAIT_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares a single-port data RAM (async read, sync write) between
//             the core M-stage port and an auxiliary master. CPU has priority;
//             aux takes idle CPU slots or a forced slot after MAX_WAIT cycles,
//             stalling the core for that one cycle.
//  Options  : DMEM_ARB_STATS_EN adds saturating stall / aux-grant counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]   stall_cnt_o,
    output logic [31:0]   aux_cnt_o,
`endif
    input  logic [31:0]   cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    input  logic          cpu_we_i,
    input  logic          cpu_re_i,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_stall_o,
    input  logic          aux_req_i,
    input  logic          aux_we_i,
    input  logic [31:0]   aux_addr_i,
    input  logic [DW-1:0] aux_wdata_i,
    output logic          aux_gnt_o,
    output logic          aux_rvalid_o,
    output logic [DW-1:0] aux_rdata_o,
    output logic [AW-1:0] ram_a_o,
    output logic [DW-1:0] ram_d_o,
    output logic          ram_we_o,
    input  logic [DW-1:0] ram_spo_i
);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    owner_e     w_owner;
    logic       w_cpu_act;
    logic       w_cnt_clr;
    logic       w_cnt_inc;
    logic       w_cnt_tc;
    logic       w_aux_rd_gnt;
    logic       w_unused_addr;

    assign w_cpu_act = cpu_re_i | cpu_we_i;

    // Only the word-address field of the byte addresses reaches the RAM
    assign w_unused_addr = ^{cpu_addr_i[31:AW+2], cpu_addr_i[1:0],
                             aux_addr_i[31:AW+2], aux_addr_i[1:0]};

    dmem_arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_clr (w_cnt_clr),
        .i_inc (w_cnt_inc),
        .o_tc  (w_cnt_tc)
    );

    // Ownership is decided combinationally; while in reset the CPU owns the RAM
    assign w_owner = (rst_i && aux_req_i && (!w_cpu_act || r_state == FORCE))
                     ? OWN_AUX : OWN_CPU;

    assign aux_gnt_o    = (w_owner == OWN_AUX);
    assign w_aux_rd_gnt = aux_gnt_o & ~aux_we_i;
    assign cpu_stall_o  = rst_i & w_cpu_act & (r_state == FORCE) & aux_req_i;
    assign cpu_rdata_o  = ram_spo_i;

    // RAM port mux; the write strobe is gated by the owner's own request
    always_comb begin
        ram_a_o  = cpu_addr_i[AW+1:2];
        ram_d_o  = cpu_wdata_i;
        ram_we_o = rst_i & cpu_we_i;
        if (w_owner == OWN_AUX) begin
            ram_a_o  = aux_addr_i[AW+1:2];
            ram_d_o  = aux_wdata_i;
            ram_we_o = rst_i & aux_we_i;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a forced slot always returns to IDLE so that the CPU
    // gets at least MAX_WAIT slots between two forced aux accesses
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (aux_req_i && w_cpu_act) begin
                    w_cnt_inc   = 1'b1;
                    w_state_nxt = w_cnt_tc ? FORCE : WAIT;
                end
            end
            WAIT: begin
                if (!aux_req_i || !w_cpu_act) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                    if (w_cnt_tc) begin
                        w_state_nxt = FORCE;
                    end
                end
            end
            FORCE: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered aux read response: one-cycle valid pulse, data held after
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            aux_rvalid_o <= 1'b0;
            aux_rdata_o  <= '0;
        end else begin
            aux_rvalid_o <= w_aux_rd_gnt;
            if (w_aux_rd_gnt) begin
                aux_rdata_o <= ram_spo_i;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    // Saturating event counters for stall cycles and aux grants
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            aux_cnt_o   <= '0;
        end else begin
            if (cpu_stall_o && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (aux_gnt_o && (aux_cnt_o != '1)) begin
                aux_cnt_o <= aux_cnt_o + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration
`endif

endmodule

`default_nettype wire
